// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-edge detect, mid-bit sampling
// with a baud down-counter, and a sticky ready/framing-error pair cleared by the consumer.
module uart_rx #(
    parameter int BAUD_CYCLES = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    localparam logic [11:0] HALF_LOAD = 12'(BAUD_CYCLES / 2 - 1);
    localparam logic [11:0] FULL_LOAD = 12'(BAUD_CYCLES - 1);

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        start_edge;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= RX;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Only a falling edge seen while idle starts a frame; data-bit edges are ignored.
    assign start_edge = (state_q == IDLE) && prev_q && !sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            frm_err_q <= frm_err_d;
        end
    end

    // NOTE: every combinational output gets a hold default first, so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        rdy_d     = rdy_q;
        frm_err_d = frm_err_q;

        if (clr_rdy) begin
            rdy_d     = 1'b0;
            frm_err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    cnt_d     = HALF_LOAD;
                    idx_d     = '0;
                    rdy_d     = 1'b0;
                    frm_err_d = 1'b0;
                    state_d   = RECEIVE;
                end
            end
            RECEIVE: begin
                if (cnt_q == '0) begin
                    cnt_d = FULL_LOAD;
                    case (idx_q)
                        4'd0: begin
                            if (sync2_q) state_d = IDLE;
                            else         idx_d   = idx_q + 4'd1;
                        end
                        4'd9: begin
                            // Assigned after the clr_rdy default, so a set beats a same-cycle clear.
                            data_d    = shift_q;
                            rdy_d     = 1'b1;
                            frm_err_d = ~sync2_q;
                            state_d   = IDLE;
                        end
                        default: begin
                            shift_d = {sync2_q, shift_q[7:1]};
                            idx_d   = idx_q + 4'd1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data = data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged 8N1 frames with a short baud period,
// compared against byte-level expectations derived from the frame contents.
module tb_uart_rx;

    localparam int B       = 32;
    localparam int LAT_NOM = 9 * B + B / 2 + 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int  checks    = 0;
    int  errors    = 0;
    int  rises     = 0;
    int  exp_rises = 0;
    time fall_time = 0;
    time rise_time = 0;
    logic rdy_prev = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.BAUD_CYCLES(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always @(negedge clk) begin
        if (rdy && !rdy_prev) begin
            rises     <= rises + 1;
            rise_time <= $time;
        end
        rdy_prev <= rdy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx        = 1'b0;
        fall_time = $time;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(B);
        end
        rx = stop;
        tick(B);
        rx = 1'b1;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!rdy && n < 12 * B) begin
            tick(1);
            n++;
        end
        check({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe);
        longint lat;
        wait_rdy(tag);
        lat = longint'((rise_time - fall_time) / 10);
        check({tag, "_data"}, {24'd0, rx_data}, {24'd0, d});
        check({tag, "_frm_err"}, {31'd0, frm_err}, {31'd0, fe});
        check({tag, "_latency_ok"}, {31'd0, (lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2)}, 32'd1);
        check({tag, "_rises"}, rises, exp_rises);
    endtask

    task automatic clear_flags(input string tag);
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        check({tag, "_clr_rdy"}, {31'd0, rdy}, 32'd0);
        check({tag, "_clr_frm_err"}, {31'd0, frm_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        logic [7:0] pattern;
        int         r0;

        tick(3);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        check("reset_frm_err", {31'd0, frm_err}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Single frame, as if looped back from the transmitter.
        send_frame(8'hA5, 1'b1);
        exp_rises++;
        expect_frame("loop_a5", 8'hA5, 1'b0);
        clear_flags("loop_a5");
        tick(B);

        // Back-to-back frames with no idle gap between stop and next start.
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                wait_rdy("b2b_first");
                check("b2b_first_data", {24'd0, rx_data}, 32'h00);
                check("b2b_first_frm_err", {31'd0, frm_err}, 32'd0);
                clr_rdy = 1'b1;
                tick(1);
                clr_rdy = 1'b0;
                check("b2b_first_cleared", {31'd0, rdy}, 32'd0);
                wait_rdy("b2b_second");
                check("b2b_second_data", {24'd0, rx_data}, 32'hFF);
            end
        join
        exp_rises += 2;
        check("b2b_rises", rises, exp_rises);
        clear_flags("b2b");
        tick(B);

        // Short low glitch: must be rejected, rx_data keeps the last byte.
        r0 = rises;
        rx = 1'b0;
        tick(B / 2 - 4);
        rx = 1'b1;
        tick(12 * B);
        check("false_start_rises", rises, r0);
        check("false_start_rdy", {31'd0, rdy}, 32'd0);
        check("false_start_data", {24'd0, rx_data}, 32'hFF);

        // Framing error: stop bit driven low.
        send_frame(8'h3C, 1'b0);
        exp_rises++;
        expect_frame("frm_err_3c", 8'h3C, 1'b1);
        clear_flags("frm_err_3c");
        tick(B);

        // clr_rdy lands in the stop-sample cycle; the set must win.
        b = 8'($urandom_range(0, 255));
        fork
            send_frame(b, 1'b1);
            begin
                tick(LAT_NOM - 1);
                clr_rdy = 1'b1;
                tick(1);
                clr_rdy = 1'b0;
            end
        join
        exp_rises++;
        check("collision_rdy", {31'd0, rdy}, 32'd1);
        check("collision_data", {24'd0, rx_data}, {24'd0, b});
        clear_flags("collision");
        tick(B);

        // Random bytes, occasional bad stop bit, random idle gaps.
        for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            exp_rises++;
            expect_frame($sformatf("rand%0d", k), b, ~stop);
            clear_flags($sformatf("rand%0d", k));
            tick($urandom_range(2, 2 * B));
        end

        // Reset during bit 4 of 0x5A, then a clean 0x81.
        pattern = 8'h5A;
        rx = 1'b0;
        tick(B);
        for (int i = 0; i < 4; i++) begin
            rx = pattern[i];
            tick(B);
        end
        rx = pattern[4];
        tick(B / 2);
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(2);
        check("mid_reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("mid_reset_rdy", {31'd0, rdy}, 32'd0);
        check("mid_reset_frm_err", {31'd0, frm_err}, 32'd0);
        rst_n = 1'b1;
        tick(12 * B);
        check("aborted_frame_rises", rises, exp_rises);
        check("aborted_frame_rdy", {31'd0, rdy}, 32'd0);
        send_frame(8'h81, 1'b1);
        exp_rises++;
        expect_frame("after_reset_81", 8'h81, 1'b0);
        clear_flags("after_reset_81");
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
